// File: rtl/pqr5_core_pkg.sv
// Shared PQR5 core types: redirect controller state, source and limits.
package pqr5_core_pkg;

    typedef enum logic [1:0] {RD_IDLE, RD_FLUSH, RD_REDIR} redir_state_t;
    typedef enum logic {RD_SRC_BU, RD_SRC_TRAP} redir_src_t;

    // Flush hold is counted in a 4-bit down-counter.
    localparam int RD_FLUSH_CYC_MAX = 15;

    // Fetch addresses are halfword aligned, so bit 0 is never meaningful.
    function automatic logic [31:0] rd_align_pc(input logic [31:0] pc);
        return {pc[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/exu_redirect_ctrl.sv
// PQR5 redirect sequencer: arbitrates BU flush vs trap, holds FU/DU flush,
// then hands the redirect PC to fetch over valid/ready.
`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

module exu_redirect_ctrl
    import pqr5_core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] PC_INIT      = `PC_INIT,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_bu_flush,
    input  logic [XLEN-1:0]  i_bu_pc,
    input  logic             i_trap_req,
    input  logic [XLEN-1:0]  i_trap_pc,
    output logic             o_trap_ack,
    output logic             o_flush_fu,
    output logic             o_flush_du,
    output logic             o_stall_exu,
    output logic             o_redir_valid,
    output logic [XLEN-1:0]  o_redir_pc,
    input  logic             i_redir_ready,
    output logic [CNT_W-1:0] o_redir_cnt
);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > RD_FLUSH_CYC_MAX) begin : g_bad_flush_cycles
            $error("exu_redirect_ctrl: FLUSH_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

    redir_state_t     state_q, state_d;
    redir_src_t       src_q,   src_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [XLEN-1:0]  pc_q,    pc_d;
    logic             ack_q,   ack_d;
    logic [CNT_W-1:0] rcnt_q,  rcnt_d;

    logic handshake;
    logic take_trap;

    // A trap is taken from IDLE, or preempts a BU redirect that is not
    // retiring this cycle; a trap redirect is never preempted.
    always_comb begin
        handshake = (state_q == RD_REDIR) && i_redir_ready;
        take_trap = i_trap_req &&
                    ((state_q == RD_IDLE) || ((src_q == RD_SRC_BU) && !handshake));
    end

    // Next-state: FSM sequencing, flush countdown, target capture, perf count.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ack_d   = 1'b0;
        rcnt_d  = rcnt_q;
        case (state_q)
            RD_IDLE: begin
                if (i_bu_flush) begin
                    pc_d    = {i_bu_pc[XLEN-1:1], 1'b0};
                    src_d   = RD_SRC_BU;
                    cnt_d   = CNT_RELOAD;
                    state_d = RD_FLUSH;
                end
            end
            RD_FLUSH: begin
                if (cnt_q == 4'd0) state_d = RD_REDIR;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RD_REDIR: begin
                if (i_redir_ready) begin
                    state_d = RD_IDLE;
                    if (rcnt_q != '1) rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            default: state_d = RD_IDLE;
        endcase
        // Trap capture overrides whatever the BU path decided above.
        if (take_trap) begin
            pc_d    = {i_trap_pc[XLEN-1:1], 1'b0};
            src_d   = RD_SRC_TRAP;
            cnt_d   = CNT_RELOAD;
            ack_d   = 1'b1;
            state_d = RD_FLUSH;
        end
    end

    // State registers; reset drops any redirect in flight without an ack.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= RD_IDLE;
            src_q   <= RD_SRC_BU;
            cnt_q   <= 4'd0;
            pc_q    <= PC_INIT;
            ack_q   <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ack_q   <= ack_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Outputs decode purely from registered state.
    always_comb begin
        o_flush_fu    = (state_q == RD_FLUSH);
        o_flush_du    = (state_q == RD_FLUSH);
        o_stall_exu   = (state_q != RD_IDLE);
        o_redir_valid = (state_q == RD_REDIR);
        o_redir_pc    = {pc_q[XLEN-1:1], 1'b0};
        o_trap_ack    = ack_q;
        o_redir_cnt   = rcnt_q;
    end

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Self-checking bench for exu_redirect_ctrl: scenario tasks plus a redirect
// scoreboard popped on every fetch handshake.
module tb_exu_redirect_ctrl;

    localparam int          XLEN    = 32;
    localparam logic [31:0] PC_INIT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        i_bu_flush, i_trap_req, i_redir_ready;
    logic [31:0] i_bu_pc, i_trap_pc;
    logic        o_trap_ack, o_flush_fu, o_flush_du, o_stall_exu, o_redir_valid;
    logic [31:0] o_redir_pc;
    logic [15:0] o_redir_cnt;

    // Second instance: short counter and single-cycle flush.
    logic        s_bu_flush, s_trap_req, s_redir_ready;
    logic [31:0] s_bu_pc, s_trap_pc;
    logic        s_trap_ack, s_flush_fu, s_flush_du, s_stall_exu, s_redir_valid;
    logic [31:0] s_redir_pc;
    logic [2:0]  s_redir_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    wire [4:0] ctl  = {o_flush_fu, o_flush_du, o_stall_exu, o_redir_valid, o_trap_ack};
    wire [4:0] sctl = {s_flush_fu, s_flush_du, s_stall_exu, s_redir_valid, s_trap_ack};

    always #5 clk = ~clk;

    exu_redirect_ctrl #(.XLEN(XLEN), .PC_INIT(PC_INIT), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .aresetn(aresetn),
        .i_bu_flush(i_bu_flush), .i_bu_pc(i_bu_pc),
        .i_trap_req(i_trap_req), .i_trap_pc(i_trap_pc), .o_trap_ack(o_trap_ack),
        .o_flush_fu(o_flush_fu), .o_flush_du(o_flush_du), .o_stall_exu(o_stall_exu),
        .o_redir_valid(o_redir_valid), .o_redir_pc(o_redir_pc),
        .i_redir_ready(i_redir_ready), .o_redir_cnt(o_redir_cnt)
    );

    exu_redirect_ctrl #(.XLEN(XLEN), .PC_INIT(PC_INIT), .FLUSH_CYCLES(1), .CNT_W(3)) u_sat (
        .clk(clk), .aresetn(aresetn),
        .i_bu_flush(s_bu_flush), .i_bu_pc(s_bu_pc),
        .i_trap_req(s_trap_req), .i_trap_pc(s_trap_pc), .o_trap_ack(s_trap_ack),
        .o_flush_fu(s_flush_fu), .o_flush_du(s_flush_du), .o_stall_exu(s_stall_exu),
        .o_redir_valid(s_redir_valid), .o_redir_pc(s_redir_pc),
        .i_redir_ready(s_redir_ready), .o_redir_cnt(s_redir_cnt)
    );

    // Scoreboard: every fetch handshake must match the oldest expected target.
    always @(negedge clk) begin
        if (aresetn && o_redir_valid && i_redir_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected redirect pc=%h with no expected entry", o_redir_pc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb.pop_front();
                if (o_redir_pc !== exp_pc) begin
                    errors++;
                    $display("FAIL sb_pc got=%h exp=%h", o_redir_pc, exp_pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        aresetn = 1'b0;
        #1;
        sb.delete();
        cyc();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rst_ctl got=%b exp=%b", ctl, 5'b00000); end
        checks++; if (o_redir_pc !== PC_INIT) begin errors++; $display("FAIL rst_pc got=%h exp=%h", o_redir_pc, PC_INIT); end
        checks++; if (o_redir_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", o_redir_cnt); end
        checks++; if (sctl !== 5'b00000) begin errors++; $display("FAIL rst_sat_ctl got=%b exp=%b", sctl, 5'b00000); end
        cyc();
        aresetn = 1'b1;
    endtask

    task automatic test_bu_basic();
        i_redir_ready = 1'b1; i_bu_flush = 1'b1; i_bu_pc = 32'h100; sb.push_back(32'h100);
        cyc(); i_bu_flush = 1'b0;
        checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL bu_flush1 ctl got=%b exp=%b", ctl, 5'b11100); end
        checks++; if (o_redir_pc !== 32'h100) begin errors++; $display("FAIL bu_pc_cap got=%h exp=%h", o_redir_pc, 32'h100); end
        cyc();
        checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL bu_flush2 ctl got=%b exp=%b", ctl, 5'b11100); end
        cyc();
        checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL bu_redir ctl got=%b exp=%b", ctl, 5'b00110); end
        cyc();
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL bu_idle ctl got=%b exp=%b", ctl, 5'b00000); end
        checks++; if (o_redir_cnt !== 16'd1) begin errors++; $display("FAIL bu_cnt got=%0d exp=1", o_redir_cnt); end
    endtask

    task automatic test_trap_wins();
        i_redir_ready = 1'b1;
        i_trap_req = 1'b1; i_trap_pc = 32'h10; i_bu_flush = 1'b1; i_bu_pc = 32'h200;
        sb.push_back(32'h10);
        cyc(); i_bu_flush = 1'b0;
        checks++; if (ctl !== 5'b11101) begin errors++; $display("FAIL tw_ack ctl got=%b exp=%b", ctl, 5'b11101); end
        checks++; if (o_redir_pc !== 32'h10) begin errors++; $display("FAIL tw_pc got=%h exp=%h", o_redir_pc, 32'h10); end
        // A second trap arrives while the first is in flight: it must wait.
        i_trap_pc = 32'h60; sb.push_back(32'h60);
        cyc();
        checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL tw_noack_flush ctl got=%b exp=%b", ctl, 5'b11100); end
        cyc();
        checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL tw_redir ctl got=%b exp=%b", ctl, 5'b00110); end
        cyc();
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL tw_idle ctl got=%b exp=%b", ctl, 5'b00000); end
        checks++; if (o_redir_cnt !== 16'd1) begin errors++; $display("FAIL tw_cnt got=%0d exp=1", o_redir_cnt); end
        cyc(); i_trap_req = 1'b0;
        checks++; if (ctl !== 5'b11101) begin errors++; $display("FAIL tw_ack2 ctl got=%b exp=%b", ctl, 5'b11101); end
        cyc(); cyc();
        checks++; if (ctl !== 5'b00110 || o_redir_pc !== 32'h60) begin errors++; $display("FAIL tw_redir2 ctl got=%b pc=%h exp=%b pc=%h", ctl, o_redir_pc, 5'b00110, 32'h60); end
        cyc();
        checks++; if (o_redir_cnt !== 16'd2) begin errors++; $display("FAIL tw_cnt2 got=%0d exp=2", o_redir_cnt); end
    endtask

    task automatic test_preempt();
        i_redir_ready = 1'b1; i_bu_flush = 1'b1; i_bu_pc = 32'h301;
        cyc(); i_bu_flush = 1'b0;
        checks++; if (o_redir_pc !== 32'h300) begin errors++; $display("FAIL pe_lsb got=%h exp=%h", o_redir_pc, 32'h300); end
        cyc();
        checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL pe_flush2 ctl got=%b exp=%b", ctl, 5'b11100); end
        i_trap_req = 1'b1; i_trap_pc = 32'h20; sb.push_back(32'h20);
        cyc(); i_trap_req = 1'b0;
        checks++; if (ctl !== 5'b11101 || o_redir_pc !== 32'h20) begin errors++; $display("FAIL pe_ack ctl got=%b pc=%h exp=%b pc=%h", ctl, o_redir_pc, 5'b11101, 32'h20); end
        cyc();
        checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL pe_reflush ctl got=%b exp=%b", ctl, 5'b11100); end
        cyc();
        checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL pe_redir ctl got=%b exp=%b", ctl, 5'b00110); end
        cyc();
        checks++; if (ctl !== 5'b00000 || o_redir_cnt !== 16'd1) begin errors++; $display("FAIL pe_idle ctl got=%b cnt=%0d exp=%b cnt=1", ctl, o_redir_cnt, 5'b00000); end
    endtask

    task automatic test_backpressure();
        i_redir_ready = 1'b0; i_bu_flush = 1'b1; i_bu_pc = 32'h400; sb.push_back(32'h400);
        cyc(); i_bu_flush = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (ctl !== 5'b00110 || o_redir_pc !== 32'h400) begin errors++; $display("FAIL bp_hold%0d ctl got=%b pc=%h exp=%b pc=%h", i, ctl, o_redir_pc, 5'b00110, 32'h400); end
            // A BU flush while busy must be ignored.
            if (i == 1) begin i_bu_flush = 1'b1; i_bu_pc = 32'h998; end
            if (i == 2) i_bu_flush = 1'b0;
        end
        cyc();
        checks++; if (ctl !== 5'b00110 || o_redir_pc !== 32'h400) begin errors++; $display("FAIL bp_last ctl got=%b pc=%h exp=%b pc=%h", ctl, o_redir_pc, 5'b00110, 32'h400); end
        i_redir_ready = 1'b1;
        cyc();
        checks++; if (ctl !== 5'b00000 || o_redir_cnt !== 16'd1) begin errors++; $display("FAIL bp_idle ctl got=%b cnt=%0d exp=%b cnt=1", ctl, o_redir_cnt, 5'b00000); end
    endtask

    task automatic test_hs_trap();
        i_redir_ready = 1'b1; i_bu_flush = 1'b1; i_bu_pc = 32'h80;
        sb.push_back(32'h80); sb.push_back(32'h40);
        cyc(); i_bu_flush = 1'b0;
        cyc(); cyc();
        checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL hs_redir ctl got=%b exp=%b", ctl, 5'b00110); end
        i_trap_req = 1'b1; i_trap_pc = 32'h40;
        cyc();
        checks++; if (ctl !== 5'b00000 || o_redir_cnt !== 16'd1) begin errors++; $display("FAIL hs_retire ctl got=%b cnt=%0d exp=%b cnt=1", ctl, o_redir_cnt, 5'b00000); end
        cyc(); i_trap_req = 1'b0;
        checks++; if (ctl !== 5'b11101 || o_redir_pc !== 32'h40) begin errors++; $display("FAIL hs_ack ctl got=%b pc=%h exp=%b pc=%h", ctl, o_redir_pc, 5'b11101, 32'h40); end
        cyc(); cyc();
        checks++; if (ctl !== 5'b00110) begin errors++; $display("FAIL hs_redir2 ctl got=%b exp=%b", ctl, 5'b00110); end
        cyc();
        checks++; if (o_redir_cnt !== 16'd2) begin errors++; $display("FAIL hs_cnt got=%0d exp=2", o_redir_cnt); end
    endtask

    task automatic test_reset_mid();
        i_redir_ready = 1'b0; i_bu_flush = 1'b1; i_bu_pc = 32'h700;
        cyc(); i_bu_flush = 1'b0;
        cyc(); cyc();
        checks++; if (ctl !== 5'b00110 || o_redir_pc !== 32'h700) begin errors++; $display("FAIL rm_pre ctl got=%b pc=%h exp=%b pc=%h", ctl, o_redir_pc, 5'b00110, 32'h700); end
        #2; aresetn = 1'b0; #1;
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rm_ctl got=%b exp=%b", ctl, 5'b00000); end
        checks++; if (o_redir_pc !== PC_INIT || o_redir_cnt !== 16'd0) begin errors++; $display("FAIL rm_pc_cnt pc=%h cnt=%0d exp pc=%h cnt=0", o_redir_pc, o_redir_cnt, PC_INIT); end
        cyc();
        aresetn = 1'b1; i_redir_ready = 1'b1;
        cyc();
        checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rm_after ctl got=%b exp=%b", ctl, 5'b00000); end
    endtask

    task automatic test_saturate();
        s_redir_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            s_bu_flush = 1'b1; s_bu_pc = 32'(k) << 4;
            cyc(); s_bu_flush = 1'b0;
            checks++; if (sctl !== 5'b11100) begin errors++; $display("FAIL sat_flush%0d ctl got=%b exp=%b", k, sctl, 5'b11100); end
            cyc();
            checks++; if (sctl !== 5'b00110 || s_redir_pc !== (32'(k) << 4)) begin errors++; $display("FAIL sat_redir%0d ctl got=%b pc=%h exp=%b pc=%h", k, sctl, s_redir_pc, 5'b00110, 32'(k) << 4); end
            cyc();
            checks++; if (s_redir_cnt !== 3'((k > 7) ? 7 : k)) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, s_redir_cnt, (k > 7) ? 7 : k); end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        i_bu_flush = 1'b0; i_bu_pc = '0; i_trap_req = 1'b0; i_trap_pc = '0; i_redir_ready = 1'b0;
        s_bu_flush = 1'b0; s_bu_pc = '0; s_trap_req = 1'b0; s_trap_pc = '0; s_redir_ready = 1'b0;
        repeat (3) cyc();
        test_reset();
        test_bu_basic();
        do_reset();
        test_trap_wins();
        do_reset();
        test_preempt();
        do_reset();
        test_backpressure();
        do_reset();
        test_hs_trap();
        test_reset_mid();
        test_saturate();
        cyc();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover entries=%0d exp=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
